// File: rtl/cascade_pkg.sv
// cascade_pkg: acknowledge-sequencer states and vec_sel byte codes.
package cascade_pkg;
    typedef enum logic [2:0] {
        S_IDLE, S_ARMED, S_P1, S_GAP1, S_P2, S_GAP2, S_P3
    } state_t;
    localparam logic [1:0] VEC_8086 = 2'd0;
    localparam logic [1:0] VEC_CALL = 2'd1;
    localparam logic [1:0] VEC_LO   = 2'd2;
    localparam logic [1:0] VEC_HI   = 2'd3;
endpackage

// File: rtl/inta_edge_detect.sv
// inta_edge_detect: registered fall/rise pulses of the clk-synchronous INTA strobe.
module inta_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic inta_n,
    output logic inta_fall,
    output logic inta_rise
);
    logic r_cur;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cur     <= 1'b1;
            inta_fall <= 1'b0;
            inta_rise <= 1'b0;
        end else begin
            r_cur     <= inta_n;
            inta_fall <= r_cur & ~inta_n;
            inta_rise <= ~r_cur & inta_n;
        end
    end
endmodule

// File: rtl/cascade_inta_sequencer.sv
// cascade_inta_sequencer: 8259A INTA sequencing for single/master/slave roles.
// CASCADE_8080_MODE_EN adds the upm input and the three-pulse 8080 CALL sequence.
module cascade_inta_sequencer
    import cascade_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       sp,
    input  logic       sngl,
    input  logic [7:0] icw3,
    input  logic       aeoi,
`ifdef CASCADE_8080_MODE_EN
    input  logic       upm,
`endif
    input  logic       int_req,
    input  logic [2:0] int_level,
    input  logic       inta_n,
    input  logic [2:0] cas_in,
    output logic       int_out,
    output logic       freeze,
    output logic       isr_set,
    output logic [2:0] isr_level,
    output logic       cas_oe,
    output logic [2:0] cas_out,
    output logic       vec_en,
    output logic [1:0] vec_sel,
    output logic       eoi_pulse
);
    state_t     r_state;
    logic       r_spur, r_hit, r_m80, r_resp;
    logic       w_fall, w_rise, w_upm, w_spur, w_hit, w_resp, w_last, w_eoi;
    logic [2:0] w_lvl;

    inta_edge_detect u_edge (
        .clk      (clk),
        .reset    (reset),
        .inta_n   (inta_n),
        .inta_fall(w_fall),
        .inta_rise(w_rise)
    );

`ifdef CASCADE_8080_MODE_EN
    assign w_upm = upm;
`else
    assign w_upm = 1'b1;
`endif

    // A fall outside ARMED-with-request is a spurious acknowledge: report IR7.
    assign w_spur = !(r_state == S_ARMED && int_req);
    assign w_lvl  = w_spur ? 3'd7 : int_level;
    assign w_hit  = sp & ~sngl & icw3[w_lvl] & ~w_spur;
    assign w_resp = sngl | (sp ? ~r_hit : (cas_in == icw3[2:0]));
    assign w_last = (r_state == S_P2 && !r_m80) || r_state == S_P3;
    assign w_eoi  = aeoi & ~r_spur & (sp | sngl | r_resp);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_spur    <= 1'b0;
            r_hit     <= 1'b0;
            r_m80     <= 1'b0;
            r_resp    <= 1'b0;
            int_out   <= 1'b0;
            freeze    <= 1'b0;
            isr_set   <= 1'b0;
            isr_level <= 3'd0;
            cas_oe    <= 1'b0;
            cas_out   <= 3'd0;
            vec_en    <= 1'b0;
            vec_sel   <= VEC_8086;
            eoi_pulse <= 1'b0;
        end else begin
            isr_set   <= 1'b0;
            eoi_pulse <= 1'b0;
            case (r_state)
                S_IDLE, S_ARMED: begin
                    if (w_fall) begin
                        r_state   <= S_P1;
                        int_out   <= 1'b0;
                        freeze    <= 1'b1;
                        isr_level <= w_lvl;
                        isr_set   <= ~w_spur;
                        r_spur    <= w_spur;
                        r_hit     <= w_hit;
                        cas_oe    <= w_hit;
                        cas_out   <= w_hit ? w_lvl : 3'd0;
                        r_m80     <= ~w_upm;
                        vec_en    <= ~w_upm & (sp | sngl);
                        vec_sel   <= w_upm ? VEC_8086 : VEC_CALL;
                    end else begin
                        r_state <= int_req ? S_ARMED : S_IDLE;
                        int_out <= int_req;
                    end
                end
                S_P1: begin
                    if (w_rise) begin
                        r_state <= S_GAP1;
                        vec_en  <= 1'b0;
                    end
                end
                S_GAP1: begin
                    if (w_fall) begin
                        r_state <= S_P2;
                        r_resp  <= w_resp;
                        vec_en  <= w_resp;
                        vec_sel <= r_m80 ? VEC_LO : VEC_8086;
                    end
                end
                S_P2: begin
                    if (w_rise) begin
                        r_state <= S_GAP2;
                        vec_en  <= 1'b0;
                    end
                end
                S_GAP2: begin
                    if (w_fall) begin
                        r_state <= S_P3;
                        r_resp  <= w_resp;
                        vec_en  <= w_resp;
                        vec_sel <= VEC_HI;
                    end
                end
                default: ;
            endcase
            // The last byte's rise overrides the per-state step above.
            if (w_last && w_rise) begin
                r_state   <= S_IDLE;
                freeze    <= 1'b0;
                cas_oe    <= 1'b0;
                cas_out   <= 3'd0;
                vec_en    <= 1'b0;
                vec_sel   <= VEC_8086;
                eoi_pulse <= w_eoi;
            end
        end
    end
endmodule

// File: doc/cascade_inta_sequencer.md
# cascade_inta_sequencer

Sequences the 8259A interrupt-acknowledge (INTA) cycle for one PIC device in single, master or slave role. It sits between the priority resolver / ISR logic and the cascade buffer/comparator. It raises INT, counts INTA pulses, drives the CAS bus as master, decides whether this device owns the vector byte, and issues the ISR-set and auto-EOI strobes.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `sp`  in  1  1 = master, 0 = slave
- `sngl`  in  1  1 = single (no cascade)
- `icw3`  in  8  master: slave-present mask per IR; slave: bits [2:0] = own ID
- `aeoi`  in  1  auto-EOI enabled (ICW4)
- `int_req`  in  1  resolver has an unmasked pending request
- `int_level`  in  3  resolver's winning IR level
- `inta_n`  in  1  INTA strobe, synchronous to `clk`, active-low
- `cas_in`  in  3  sampled CAS bus
- `int_out`  out  1  INT to CPU/master
- `freeze`  out  1  hold resolver/IRR during the acknowledge
- `isr_set`  out  1  one-cycle strobe: set ISR bit `isr_level`
- `isr_level`  out  3  level latched at first INTA
- `cas_oe`  out  1  drive CAS (master only)
- `cas_out`  out  3  CAS value = latched level
- `vec_en`  out  1  drive data bus this pulse
- `vec_sel`  out  2  0 = 8086 vector, 1 = CALL opcode, 2 = addr low, 3 = addr high
- `eoi_pulse`  out  1  one-cycle auto-EOI strobe

## Operation
- Edges are taken from a registered sample of `inta_n`. Fall = previous 1, current 0. Rise = previous 0, current 1.
- States:
  - IDLE: `int_out` = 0.
  - ARMED: `int_out` = 1.
  - P1, GAP1, P2, GAP2, P3: the pulse and inter-pulse phases.
- IDLE→ARMED when `int_req`=1. ARMED→IDLE if `int_req` drops before any INTA fall.
- A fall in IDLE or ARMED enters P1. Pulses are tracked even when idle, so slaves stay aligned with the bus.
- On entering P1:
  - `freeze`=1 and `int_out`=0.
  - Latch `isr_level` = `int_level`.
  - Pulse `isr_set` only if the state was ARMED and `int_req`=1.
  - Otherwise the acknowledge is spurious: latch level 7 and give no `isr_set`.
- Slave-on-level flag (`cas_hit`) = `sp` & ~`sngl` & `icw3[latched level]` & not spurious.
  - While `cas_hit`=1: `cas_oe`=1 and `cas_out` = level, from P1 entry until the final rise.
- Responder:
  - `sngl`=1: always.
  - Master: when `cas_hit`=0.
  - Slave: when `cas_in` == `icw3[2:0]`, sampled at each byte-pulse fall.
  - A slave never responds on P1 in 8086 mode.
- 8086 sequence: P1 → rise → GAP1 → fall → P2 → rise → IDLE.
  - In P2, `vec_en` = responder and `vec_sel`=0.
- The final rise ends the sequence:
  - `freeze`=0 and `cas_oe`=0.
  - `eoi_pulse` fires for one cycle if `aeoi`=1, the acknowledge was not spurious, and the device is master/single or a slave responder.
- A new `int_req` during the sequence is ignored. `int_out` can reassert no earlier than 1 cycle after return to IDLE.
- Reset (any time, including mid-sequence): state IDLE. All outputs are 0 immediately, including `cas_oe` and `vec_en`, with no `eoi_pulse`.

## Timing
- Latency is 1 clk from the sampled edge to the registered output change. `vec_en` is deasserted 1 clk after the rise.
- `isr_set` and `eoi_pulse` are exactly 1 clk wide.
- `int_out` rises 1 clk after `int_req` is sampled high.
- Minimum INTA low or high width is 2 clk. Shorter glitches are undefined and do not need to be checked.

## Configuration
- `CASCADE_8080_MODE_EN` defined:
  - Adds input `upm` (1 = 8086, 0 = 8080).
  - With `upm`=0 the sequence is P1 → GAP1 → P2 → GAP2 → P3 → IDLE, and the final rise is P3's.
  - P1: master/single drives `vec_sel`=1 (CALL opcode); slaves stay silent.
  - P2: responder drives `vec_sel`=2. P3: responder drives `vec_sel`=3.
- Undefined: there is no `upm` port and the block is 8086-only. GAP2 and P3 are unreachable and may be removed.

## Structure
- `cascade_pkg`: state enum and the `vec_sel` constants (`VEC_8086`, `VEC_CALL`, `VEC_LO`, `VEC_HI`).
- Sub-module `inta_edge_detect` takes `clk`, `reset` and `inta_n`, and produces registered `inta_fall` and `inta_rise`.

## Test plan
- Single, `int_req`=1 level 5, two pulses: `int_out` drops at P1, `isr_set` shows level 5, `vec_en`/`vec_sel`=0 in P2, `cas_oe` stays 0.
- Master, `icw3`=8'h09, level 3, two pulses: `cas_oe`=1 with `cas_out`=3 from P1 to the final rise, `vec_en` stays 0.
- Slave with ID 3 and `cas_in`=3, then a second run with `cas_in`=0: `vec_en`=1 in P2 for the first run only. A slave with `aeoi`=1 gets `eoi_pulse` only on the matching run.
- `int_req` drops 1 clk before the INTA fall: `isr_level`=7, no `isr_set`, master `vec_en`=1 in P2, no `eoi_pulse`.
- Reset asserted during GAP1 of a master run: `cas_oe`, `freeze` and `int_out` go to 0 immediately. The next sequence starts cleanly from IDLE.
- With `CASCADE_8080_MODE_EN` and `upm`=0, master level 2 and `icw3`=0: three pulses give `vec_sel` 1, 2, 3, and `eoi_pulse` (with `aeoi`=1) follows the third rise.
